// File: rtl/pe_32b.sv
// Registered 32-bit MSB-first priority encoder: index + any-set flag, 1-cycle latency.
// No backpressure: a new request word is accepted every cycle.
// Built as four 8-bit sub-encoders feeding a 4-way group selector to keep the critical path shallow.

module pe_32b_enc8 (
  input  logic [7:0] req,
  output logic [2:0] idx,
  output logic       any
);
  always_comb begin
    idx = 3'd0;
    any = |req;
    // Ascending scan so the highest set bit wins the final assignment
    for (int i = 0; i < 8; i++) begin
      if (req[i]) idx = 3'(i);
    end
  end
endmodule

module pe_32b (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] in,
  output logic        val,
  output logic [4:0]  out
);
  localparam int W  = 32;
  localparam int IW = $clog2(W);
  localparam int NG = W / 8;

  logic [NG-1:0]      grp_any;
  logic [2:0]         grp_idx [NG];
  logic [1:0]         sel;
  logic [2:0]         sel_idx;
  logic [IW-1:0]      nxt_out;
  logic               nxt_val;

  for (genvar g = 0; g < NG; g++) begin : g_enc
    pe_32b_enc8 u_enc (
      .req (in[g*8 +: 8]),
      .idx (grp_idx[g]),
      .any (grp_any[g])
    );
  end

  // Group 3 (bits 31:24) has the highest priority
  always_comb begin
    sel = 2'd0;
    casez (grp_any)
      4'b1???: sel = 2'd3;
      4'b01??: sel = 2'd2;
      4'b001?: sel = 2'd1;
      default: sel = 2'd0;
    endcase
  end

  // An empty word falls through to group 0, whose local index is also 0
  assign sel_idx = grp_idx[sel];
  assign nxt_out = {sel, sel_idx};
  assign nxt_val = |grp_any;

  always_ff @(posedge clk) begin
    if (!rst) begin
      out <= '0;
      val <= 1'b0;
    end else begin
      out <= nxt_out;
      val <= nxt_val;
    end
  end
endmodule

// File: tb/tb_pe_32b.sv
// Directed bench for pe_32b: reset, one-hot walk, multi-hot priority, zero input,
// back-to-back random words and mid-stream reset, each checked against a bit-scan model.

module tb_pe_32b;
  logic        clk;
  logic        rst;
  logic [31:0] in;
  logic        val;
  logic [4:0]  out;

  int n_assert;
  int n_fail;

  pe_32b dut (
    .clk (clk),
    .rst (rst),
    .in  (in),
    .val (val),
    .out (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, observed no completion, expected finish");
    $fatal(1, "watchdog");
  end

  // Scans down from bit 31; returns {val, out}
  function automatic logic [5:0] model(input logic [31:0] v);
    for (int i = 31; i >= 0; i--) begin
      if (v[i]) return {1'b1, 5'(i)};
    end
    return 6'd0;
  endfunction

  task automatic chk(input string tag, input logic exp_val, input logic [4:0] exp_out);
    n_assert++;
    assert (val === exp_val) else begin
      n_fail++;
      $error("FAIL %s val: observed %b expected %b", tag, val, exp_val);
    end
    n_assert++;
    assert (out === exp_out) else begin
      n_fail++;
      $error("FAIL %s out: observed %0d expected %0d", tag, out, exp_out);
    end
  endtask

  // Drive one word, clock it in, check the registered result one cycle later
  task automatic step(input string tag, input logic r, input logic [31:0] v);
    logic [5:0] e;
    rst = r;
    in  = v;
    @(posedge clk);
    #1;
    e = r ? model(v) : 6'd0;
    chk(tag, e[5], e[4:0]);
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst = 1'b0;
    in  = 32'hFFFF_FFFF;
    #2;

    // Reset holds outputs at zero regardless of the request word
    step("reset_edge1", 1'b0, 32'hFFFF_FFFF);
    step("reset_edge2", 1'b0, 32'hFFFF_FFFF);
    chk("reset_const", 1'b0, 5'd0);
    step("reset_release", 1'b1, 32'hFFFF_FFFF);
    chk("all_ones", 1'b1, 5'd31);

    // One-hot walk across every sub-encoder and group boundary
    for (int k = 0; k < 32; k++) begin
      step($sformatf("onehot_%0d", k), 1'b1, 32'd1 << k);
      chk($sformatf("onehot_lit_%0d", k), 1'b1, 5'(k));
    end

    // Multi-hot: lower set bits must be ignored
    step("multi_a", 1'b1, 32'b0000_0010_0100_0001_0000_0010_0000_0000);
    chk("multi_a_lit", 1'b1, 5'd25);
    step("multi_b", 1'b1, 32'b0001_0001_0000_0000_1000_0001_0000_0000);
    chk("multi_b_lit", 1'b1, 5'd28);
    step("multi_c", 1'b1, 32'b1000_0001_0000_0100_0100_0000_1000_0000);
    chk("multi_c_lit", 1'b1, 5'd31);

    // Zero versus bit 0: only val tells them apart
    step("zero", 1'b1, 32'h0000_0000);
    chk("zero_lit", 1'b0, 5'd0);
    step("bit0", 1'b1, 32'h0000_0001);
    chk("bit0_lit", 1'b1, 5'd0);
    step("msb", 1'b1, 32'h8000_0000);
    chk("msb_lit", 1'b1, 5'd31);

    // Back-to-back words, a new one every cycle, including zeros and sparse words
    for (int n = 0; n < 64; n++) begin
      logic [31:0] v;
      case (n % 8)
        0:       v = 32'h0;
        1:       v = 32'd1 << $urandom_range(31, 0);
        2:       v = $urandom & $urandom & $urandom;
        default: v = $urandom;
      endcase
      step($sformatf("b2b_%0d", n), 1'b1, v);
    end

    // Mid-stream reset drops the pending result for exactly one edge
    step("mid_pre", 1'b1, 32'h0000_0400);
    chk("mid_pre_lit", 1'b1, 5'd10);
    step("mid_rst", 1'b0, 32'h0000_0400);
    chk("mid_rst_lit", 1'b0, 5'd0);
    step("mid_post", 1'b1, 32'h0000_0400);
    chk("mid_post_lit", 1'b1, 5'd10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
